keypad_scanner: RTL

//  Scans a 4x4 matrix keypad: drives one active-low column strobe at a time and samples the active-low rows.

---
 rtl/keypad_pkg.sv | 15 +
 rtl/keypad_scanner_sync_2ff.sv | 20 ++
 rtl/keypad_scanner.sv | 98 +++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: scanner states and keypad decoding helpers
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
  localparam logic [63:0] KEYMAP = 64'h123A_456B_789C_E0FD;
  // Row 0 / col 0 sits in the top nibble, so the bit offset is the inverted {row,col}.
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    return KEYMAP[{~row, ~col, 2'b00} +: 4];
  endfunction
  function automatic logic [1:0] lowest_low(input logic [3:0] v);
    return !v[0] ? 2'd0 : !v[1] ? 2'd1 : !v[2] ? 2'd2 : 2'd3;
  endfunction
  function automatic logic [1:0] col_idx(input logic [3:0] cols);
    return !cols[0] ? 2'd0 : !cols[1] ? 2'd1 : !cols[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// sync_2ff: two-flop synchronizer that resets to all-ones (idle keypad rows)
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '1;
      q      <= '1;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scan with press/release debounce and one-cycle key reports
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 4096,
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic       Osc,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);
  state_t        state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    cols_q, cols_d, key_q, key_d, rs, next_cols;
  logic          valid_q, valid_d, held_q, held_d, row_hi;
  sync_2ff #(.W(4)) u_sync (.clk(Osc), .rst(reset), .d(rows), .q(rs));
  assign row_hi    = rs[row_q];
  assign next_cols = {cols_q[2:0], cols_q[3]};
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    cols_d  = cols_q;
    key_d   = key_q;
    valid_d = 1'b0;
    held_d  = held_q;
    case (state_q)
      SCAN: begin
        // rows are only trusted on the last dwell cycle, once the synchronizer reflects this column
        dwell_d = (dwell_q == DWELL_LAST) ? '0 : dwell_q + DW'(1);
        if (dwell_q == DWELL_LAST && rs != 4'hF) begin
          state_d = DEBOUNCE;
          row_d   = lowest_low(rs);
          cnt_d   = '0;
        end else if (dwell_q == DWELL_LAST) cols_d = next_cols;
      end
      DEBOUNCE: begin
        if (row_hi) begin
          state_d = SCAN;
          cols_d  = next_cols;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          key_d   = keymap(row_q, col_idx(cols_q));
          valid_d = 1'b1;
          held_d  = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      end
      HELD: begin
        state_d = row_hi ? RELEASE : HELD;
        cnt_d   = row_hi ? '0 : cnt_q;
      end
      RELEASE: begin
        if (rs != 4'hF) cnt_d = '0;
        else if (cnt_q == CNT_LAST) begin
          state_d = SCAN;
          held_d  = 1'b0;
          cols_d  = next_cols;
        end else cnt_d = cnt_q + CW'(1);
      end
    endcase
  end
  always_ff @(posedge Osc or posedge reset) begin
    if (reset) begin
      state_q <= SCAN;
      dwell_q <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      cols_q  <= 4'b1110;
      key_q   <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      cols_q  <= cols_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end
  assign cols      = cols_q;
  assign key       = key_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
endmodule
